// File: rtl/sc_flag_pkg.sv
// Shared types and sizing helpers for the second-chance flag store update path.
package sc_flag_pkg;

    localparam int FLAG_ADR_W  = 10;
    localparam int FLAG_BUCKET = 4;

    // A one-slot bucket still needs a 1-bit slot index.
    function automatic int slot_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int FLAG_SLOT_W = slot_w(FLAG_BUCKET);

    typedef enum logic {
        OP_INSERT = 1'b0,
        OP_DELETE = 1'b1
    } flag_op_e;

    typedef struct packed {
        flag_op_e                op;
        logic [FLAG_ADR_W-1:0]   adr;
        logic [FLAG_SLOT_W-1:0]  slot;
    } flag_req_t;

    typedef struct packed {
        logic                    ok;
        logic [FLAG_SLOT_W-1:0]  slot;
    } flag_res_t;

endpackage

// File: rtl/free_slot_finder.sv
// Lowest-index clear bit of a bucket valid mask; found stays low when the bucket is full.
module free_slot_finder
    import sc_flag_pkg::*;
#(
    parameter int N  = FLAG_BUCKET,
    parameter int IW = slot_w(N)
) (
    input  logic [N-1:0]  mask,
    output logic          found,
    output logic [IW-1:0] index
);

    always_comb begin
        found = 1'b0;
        index = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!mask[i]) begin
                found = 1'b1;
                index = IW'(i);
            end
        end
    end

endmodule

// File: rtl/flag_update_ctrl.sv
// Read-modify-write controller for bucket valid masks in the second-chance flag store.
// Define FLAG_UPDATE_FWD_EN for full-rate same-bucket updates through a one-entry forward register.
module flag_update_ctrl
    import sc_flag_pkg::*;
#(
    parameter int MAX_ADR_WIDTH = FLAG_ADR_W,
    parameter int BUCKET_SIZE   = FLAG_BUCKET,
    parameter int SLOT_W        = slot_w(BUCKET_SIZE)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          valid_i,
    output logic                          ready_o,
    input  logic                          op_i,
    input  logic [MAX_ADR_WIDTH-1:0]      adr_i,
    input  logic [SLOT_W-1:0]             slot_i,
    output logic [MAX_ADR_WIDTH-1:0]      flag_rd_adr_o,
    output logic                          flag_ready_o,
    input  logic [BUCKET_SIZE-1:0]        flag_rd_i,
    output logic [MAX_ADR_WIDTH-1:0]      flag_wr_adr_o,
    output logic                          flag_wr_en_o,
    output logic [BUCKET_SIZE-1:0]        flag_wr_valid_o,
    output logic                          done_o,
    input  logic                          done_ready_i,
    output logic                          done_ok_o,
    output logic [SLOT_W-1:0]             done_slot_o,
    output logic [MAX_ADR_WIDTH+SLOT_W:0] occupancy_o
);

    localparam int OCC_W = MAX_ADR_WIDTH + SLOT_W + 1;

    logic                     vld_p1;
    flag_op_e                 op_p1;
    logic [MAX_ADR_WIDTH-1:0] adr_p1;
    logic [SLOT_W-1:0]        slot_p1;
    logic                     vld_p2;
    logic                     ok_p2;
    logic [SLOT_W-1:0]        slot_p2;
    logic [OCC_W-1:0]         occ;

    logic                     advance, accept, hazard, wr_en, ok_m, found;
    logic [SLOT_W-1:0]        slot_m, free_idx;
    logic [BUCKET_SIZE-1:0]   eff_mask, new_mask;

    function automatic logic [OCC_W-1:0] occ_sat(input logic [OCC_W-1:0] cur, input logic up);
        if (up)
            return (&cur) ? cur : cur + OCC_W'(1);
        return (cur == '0) ? cur : cur - OCC_W'(1);
    endfunction

    assign advance       = !vld_p2 || done_ready_i;
    assign ready_o       = (!vld_p1 || advance) && !hazard;
    assign accept        = valid_i && ready_o;
    assign flag_rd_adr_o = adr_i;
    assign flag_ready_o  = ready_o;

`ifdef FLAG_UPDATE_FWD_EN
    logic                     fwd_vld;
    logic [MAX_ADR_WIDTH-1:0] fwd_adr;
    logic [BUCKET_SIZE-1:0]   fwd_data;

    assign hazard   = 1'b0;
    assign eff_mask = (fwd_vld && fwd_adr == adr_p1) ? fwd_data : flag_rd_i;

    // Held across stalls: the RAM output is frozen then, so the entry stays relevant.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            fwd_vld <= 1'b0;
        else if (advance)
            fwd_vld <= wr_en;
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            fwd_adr  <= adr_p1;
            fwd_data <= new_mask;
        end
    end
`else
    // Hold off a same-bucket request one cycle so its read lands after the write.
    assign hazard   = valid_i && vld_p1 && (adr_i == adr_p1);
    assign eff_mask = flag_rd_i;
`endif

    free_slot_finder #(.N(BUCKET_SIZE), .IW(SLOT_W)) u_finder (
        .mask  (eff_mask),
        .found (found),
        .index (free_idx)
    );

    always_comb begin
        new_mask = eff_mask;
        ok_m     = 1'b0;
        slot_m   = slot_p1;
        if (op_p1 == OP_INSERT) begin
            slot_m = free_idx;
            if (found) begin
                new_mask[free_idx] = 1'b1;
                ok_m               = 1'b1;
            end
        end else if (eff_mask[slot_p1]) begin
            new_mask[slot_p1] = 1'b0;
            ok_m              = 1'b1;
        end
    end

    assign wr_en           = vld_p1 && advance && (new_mask != eff_mask);
    assign flag_wr_en_o    = wr_en;
    assign flag_wr_adr_o   = wr_en ? adr_p1 : '0;
    assign flag_wr_valid_o = wr_en ? new_mask : '0;

    // R -> M
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            vld_p1 <= 1'b0;
        else if (accept)
            vld_p1 <= 1'b1;
        else if (advance)
            vld_p1 <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            op_p1   <= flag_op_e'(op_i);
            adr_p1  <= adr_i;
            slot_p1 <= slot_i;
        end
    end

    // M -> output register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p2  <= 1'b0;
            ok_p2   <= 1'b0;
            slot_p2 <= '0;
            occ     <= '0;
        end else if (advance) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                ok_p2   <= ok_m;
                slot_p2 <= slot_m;
                if (ok_m)
                    occ <= occ_sat(occ, op_p1 == OP_INSERT);
            end
        end
    end

    assign done_o      = vld_p2;
    assign done_ok_o   = ok_p2;
    assign done_slot_o = slot_p2;
    assign occupancy_o = occ;

endmodule
